// File: rtl/sync_fifo_th_pkg.sv
// Shared helpers for sync_fifo_th: pointer increment with wrap and configuration sanity check.
// Used by sync_fifo_th (optional macro SYNC_FIFO_TH_FWFT_EN selects first-word-fall-through reads).
package sync_fifo_th_pkg;

  // Next storage index; DEPTH need not be a power of two, so wrap explicitly at depth-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  // True when the increment from ptr crosses the end of storage (wrap bit must toggle).
  function automatic bit ptr_wraps(input int unsigned ptr, input int unsigned depth);
    return ptr >= depth - 1;
  endfunction

  function automatic bit cfg_ok(input int unsigned depth, input int unsigned ae_level,
                                input int unsigned af_level);
    return (depth >= 2) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_th_if.sv
// Producer/consumer bus of sync_fifo_th: write/read requests, read data, status and error flags.
// Handshake: a write is taken when wr_en_i & ~full_o and a pop when rd_en_i & ~empty_o, both
// judged at the rising edge; requests made against full/empty are dropped and flagged instead.
interface sync_fifo_th_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 5
);
  logic                 flush_i;
  logic                 clr_err_i;
  logic                 wr_en_i;
  logic [WIDTH-1:0]     wdata_i;
  logic                 rd_en_i;
  logic [WIDTH-1:0]     rdata_o;
  logic                 rvalid_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 almost_full_o;
  logic                 almost_empty_o;
  logic [CNT_WIDTH-1:0] count_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output flush_i, clr_err_i, wr_en_i, wdata_i, rd_en_i,
    input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, clr_err_i, wr_en_i, wdata_i, rd_en_i,
    output rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_mem_1w1r.sv
// Storage array for sync_fifo_th: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_1w1r #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky errors and flush.
// Define SYNC_FIFO_TH_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_th
  import sync_fifo_th_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  sync_fifo_th_if.slave   bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] AF_CNT = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT = CNT_WIDTH'(AE_LEVEL);

  if (!cfg_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_cfg
    $error("sync_fifo_th: need DEPTH>=2 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, wr_acc, rd_acc;
  logic [WIDTH-1:0]      mem_rdata;

  assign full   = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
  assign empty  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
  // Flush overrides any same-cycle traffic, so neither port is accepted then.
  assign wr_acc = bus.wr_en_i & ~full  & ~bus.flush_i;
  assign rd_acc = bus.rd_en_i & ~empty & ~bus.flush_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_wrap_d = wr_wrap_q;
    rd_ptr_d  = rd_ptr_q;
    rd_wrap_d = rd_wrap_q;
    count_d   = count_q;
    if (bus.flush_i) begin
      wr_ptr_d  = '0;
      wr_wrap_d = 1'b0;
      rd_ptr_d  = '0;
      rd_wrap_d = 1'b0;
      count_d   = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (ptr_wraps(32'(wr_ptr_q), DEPTH)) wr_wrap_d = ~wr_wrap_q;
      end
      if (rd_acc) begin
        rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DEPTH));
        if (ptr_wraps(32'(rd_ptr_q), DEPTH)) rd_wrap_d = ~rd_wrap_q;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
    // Set beats clear when both happen in the same cycle.
    ovf_d = (ovf_q & ~bus.clr_err_i) | (bus.wr_en_i & full  & ~bus.flush_i);
    udf_d = (udf_q & ~bus.clr_err_i) | (bus.rd_en_i & empty & ~bus.flush_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_ptr_q  <= '0;
      rd_wrap_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_wrap_q <= wr_wrap_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_wrap_q <= rd_wrap_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  fifo_mem_1w1r #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_TH_FWFT_EN
  assign bus.rdata_o  = empty ? '0 : mem_rdata;
  assign bus.rvalid_o = ~empty;
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_acc) begin
      rdata_d  = mem_rdata;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
`endif

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count_q >= AF_CNT);
  assign bus.almost_empty_o = (count_q <= AE_CNT);
  assign bus.count_o        = count_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;
endmodule

// File: tb/tb_sync_fifo_th.sv
// Directed bench for sync_fifo_th (DEPTH=16, WIDTH=8, AF=14, AE=2), either read mode.
// Expected words are queued on accepted writes and popped when the DUT presents/returns a word.
module tb_sync_fifo_th;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic clk;
  logic rst_ni;

  sync_fifo_th_if #(.WIDTH(WIDTH), .CNT_WIDTH(5)) bus ();

  sync_fifo_th #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit               ovf_m;
  bit               udf_m;
  logic [WIDTH-1:0] last_rd_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int unsigned cnt;
    cnt = exp_q.size();
    check({tag, ".count"}, 32'(bus.count_o), cnt);
    check({tag, ".full"}, 32'(bus.full_o), 32'(cnt == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty_o), 32'(cnt == 0));
    check({tag, ".afull"}, 32'(bus.almost_full_o), 32'(cnt >= AF));
    check({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(cnt <= AE));
    check({tag, ".ovf"}, 32'(bus.overflow_o), 32'(ovf_m));
    check({tag, ".udf"}, 32'(bus.underflow_o), 32'(udf_m));
`ifdef SYNC_FIFO_TH_FWFT_EN
    check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'(cnt != 0));
    check({tag, ".rdata"}, 32'(bus.rdata_o), (cnt != 0) ? 32'(exp_q[0]) : 32'h0);
`endif
  endtask

  task automatic reset_model();
    exp_q.delete();
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
    last_rd_m = '0;
  endtask

  task automatic check_reset(input string tag);
    check_status(tag);
    check({tag, ".rdata0"}, 32'(bus.rdata_o), 32'h0);
    check({tag, ".rvalid0"}, 32'(bus.rvalid_o), 32'h0);
  endtask

  task automatic idle_inputs();
    bus.wr_en_i   = 1'b0;
    bus.wdata_i   = '0;
    bus.rd_en_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.clr_err_i = 1'b0;
  endtask

  // One clock of stimulus; the model is judged on the state seen before the edge.
  task automatic do_cycle(input bit wr, input logic [WIDTH-1:0] wd, input bit rd,
                          input bit fl, input bit clr, input string tag);
    bit               full_m;
    bit               empty_m;
    bit               rd_acc;
    logic [WIDTH-1:0] popped;
    full_m  = (exp_q.size() == DEPTH);
    empty_m = (exp_q.size() == 0);
    rd_acc  = 1'b0;
    popped  = '0;
    bus.wr_en_i   = wr;
    bus.wdata_i   = wd;
    bus.rd_en_i   = rd;
    bus.flush_i   = fl;
    bus.clr_err_i = clr;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      rd_acc = rd && !empty_m;
      if (rd_acc) popped = exp_q.pop_front();
      if (wr && !full_m) exp_q.push_back(wd);
    end
    ovf_m = (ovf_m && !clr) || (wr && full_m && !fl);
    udf_m = (udf_m && !clr) || (rd && empty_m && !fl);
`ifndef SYNC_FIFO_TH_FWFT_EN
    if (rd_acc) begin
      check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'h1);
      check({tag, ".rdata"}, 32'(bus.rdata_o), 32'(popped));
      last_rd_m = popped;
    end else begin
      check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'h0);
      check({tag, ".rhold"}, 32'(bus.rdata_o), 32'(last_rd_m));
    end
`endif
    check_status(tag);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    reset_model();

    // 1. reset, then reset asserted mid-traffic at count 7
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check_reset("rst_rel");
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "pre_rst");
    idle_inputs();
    #3 rst_ni = 1'b0;
    #1;
    reset_model();
    check_reset("rst_async");
    @(posedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check_reset("rst_rel2");

    // 2. fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
    do_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "ovf17");
    for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain");
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_ovf");

    // 3. wrap rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++)
        do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, "wrap_wr");
      for (int i = 0; i < 10; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "wrap_rd");
    end

    // 4. simultaneous read+write at count 5, then at full
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, "sim_pre");
    for (int i = 0; i < 20; i++)
      do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, "sim_wr_rd");
    for (int i = 0; i < 11; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "sim_fill");
    do_cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "full_wr_rd");
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_ovf2");
    for (int i = 0; i < 15; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "sim_drain");

    // 5. underflow and clear priority
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "udf");
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, "udf_clr_set");
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "udf_clr");

    // 6. flush with a same-cycle write; errors must survive it
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "udf_again");
    for (int i = 0; i < 9; i++) do_cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0, "pre_flush");
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_flush_rd");
    do_cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "flush");
    do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "post_flush_wr");
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_flush_rd");
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, "idle_end");
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
